// File: rtl/pipe_wb_stage.sv
// Registered write-back stage: selects ALU/link/load data, aligns sub-word loads and
// waits for variable-latency data-memory responses before issuing a one-cycle RF write.
module pipe_wb_stage #(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned ADDR_W        = 5,
  parameter bit          ZERO_SUPPRESS = 1'b1,
  localparam int unsigned OFF_W        = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rd_waddr,
  input  logic              in_rd_wena,
  input  logic [1:0]        in_rd_sel,
  input  logic [2:0]        in_ld_type,
  input  logic [OFF_W-1:0]  in_byte_off,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_link_addr,
  input  logic              flush,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [ADDR_W-1:0] out_rd_waddr,
  output logic              out_rd_wena,
  output logic [DATA_W-1:0] out_rd_wdata,
  output logic              out_busy
);

  localparam logic [0:0] StIdle    = 1'b0;
  localparam logic [0:0] StWaitMem = 1'b1;

  localparam logic [2:0] LdLh  = 3'd1;
  localparam logic [2:0] LdLhu = 3'd2;
  localparam logic [2:0] LdLb  = 3'd3;
  localparam logic [2:0] LdLbu = 3'd4;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] pend_waddr_q, pend_waddr_d;
  logic [2:0]        pend_ld_type_q, pend_ld_type_d;
  logic [OFF_W-1:0]  pend_off_q, pend_off_d;
  logic              wena_q, wena_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              accept;
  logic              eff_wena;
  logic [2:0]        ld_type;
  logic [OFF_W-1:0]  ld_off;
  logic [OFF_W-1:0]  half_off;
  logic [DATA_W-1:0] byte_shift;
  logic [DATA_W-1:0] half_shift;
  logic [DATA_W-1:0] ld_data;

  assign in_ready = (state_q == StIdle);
  assign out_busy = (state_q == StWaitMem);
  assign accept   = in_valid && in_ready && !flush;
  assign eff_wena = in_rd_wena && !(ZERO_SUPPRESS && (in_rd_waddr == '0));

  // While waiting, alignment must use the attributes latched at accept time.
  assign ld_type  = (state_q == StWaitMem) ? pend_ld_type_q : in_ld_type;
  assign ld_off   = (state_q == StWaitMem) ? pend_off_q : in_byte_off;
  assign half_off = {ld_off[OFF_W-1:1], 1'b0};

  always_comb begin
    byte_shift = dmem_rdata >> {ld_off, 3'b000};
    half_shift = dmem_rdata >> {half_off, 3'b000};
    unique case (ld_type)
      LdLh:    ld_data = {{(DATA_W-16){half_shift[15]}}, half_shift[15:0]};
      LdLhu:   ld_data = {{(DATA_W-16){1'b0}}, half_shift[15:0]};
      LdLb:    ld_data = {{(DATA_W-8){byte_shift[7]}}, byte_shift[7:0]};
      LdLbu:   ld_data = {{(DATA_W-8){1'b0}}, byte_shift[7:0]};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    pend_waddr_d   = pend_waddr_q;
    pend_ld_type_d = pend_ld_type_q;
    pend_off_d     = pend_off_q;
    wena_d         = 1'b0;
    waddr_d        = waddr_q;
    wdata_d        = wdata_q;

    if (state_q == StIdle) begin
      // A bubble (no effective enable) never waits, even for a load.
      if (accept && eff_wena) begin
        if (in_rd_sel == 2'd0) begin
          if (dmem_rvalid) begin
            wena_d  = 1'b1;
            waddr_d = in_rd_waddr;
            wdata_d = ld_data;
          end else begin
            state_d        = StWaitMem;
            pend_waddr_d   = in_rd_waddr;
            pend_ld_type_d = in_ld_type;
            pend_off_d     = in_byte_off;
          end
        end else begin
          wena_d  = 1'b1;
          waddr_d = in_rd_waddr;
          wdata_d = (in_rd_sel == 2'd2) ? in_link_addr : in_alu_result;
        end
      end
    end else begin
      // Flush wins over a response arriving in the same cycle.
      if (flush) begin
        state_d = StIdle;
      end else if (dmem_rvalid) begin
        state_d = StIdle;
        wena_d  = 1'b1;
        waddr_d = pend_waddr_q;
        wdata_d = ld_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      pend_waddr_q   <= '0;
      pend_ld_type_q <= '0;
      pend_off_q     <= '0;
      wena_q         <= 1'b0;
      waddr_q        <= '0;
      wdata_q        <= '0;
    end else begin
      state_q        <= state_d;
      pend_waddr_q   <= pend_waddr_d;
      pend_ld_type_q <= pend_ld_type_d;
      pend_off_q     <= pend_off_d;
      wena_q         <= wena_d;
      waddr_q        <= waddr_d;
      wdata_q        <= wdata_d;
    end
  end

  assign out_rd_wena  = wena_q;
  assign out_rd_waddr = waddr_q;
  assign out_rd_wdata = wdata_q;

endmodule

// File: tb/tb_pipe_wb_stage.sv
// Directed bench for pipe_wb_stage: a transaction-level model checked every cycle,
// plus literal expectations on the observed write stream.
module tb_pipe_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rd_waddr = '0;
  logic        in_rd_wena = 1'b0;
  logic [1:0]  in_rd_sel = '0;
  logic [2:0]  in_ld_type = '0;
  logic [1:0]  in_byte_off = '0;
  logic [31:0] in_alu_result = '0;
  logic [31:0] in_link_addr = '0;
  logic        flush = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic [4:0]  out_rd_waddr;
  logic        out_rd_wena;
  logic [31:0] out_rd_wdata;
  logic        out_busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  pipe_wb_stage #(.DATA_W(32), .ADDR_W(5), .ZERO_SUPPRESS(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rd_waddr  (in_rd_waddr),
    .in_rd_wena   (in_rd_wena),
    .in_rd_sel    (in_rd_sel),
    .in_ld_type   (in_ld_type),
    .in_byte_off  (in_byte_off),
    .in_alu_result(in_alu_result),
    .in_link_addr (in_link_addr),
    .flush        (flush),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .out_rd_waddr (out_rd_waddr),
    .out_rd_wena  (out_rd_wena),
    .out_rd_wdata (out_rd_wdata),
    .out_busy     (out_busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Load extraction from arithmetic on the word value.
  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] t,
                                             input int unsigned off);
    longint unsigned wv, b, h;
    wv = longint'(w);
    b  = (wv / (64'd1 << (8 * off))) % 256;
    h  = (wv / (64'd1 << (16 * (off / 2)))) % 65536;
    case (t)
      3'd1:    return (h >= 32768) ? 32'(h + 64'hFFFF_0000) : 32'(h);
      3'd2:    return 32'(h);
      3'd3:    return (b >= 128) ? 32'(b + 64'hFFFF_FF00) : 32'(b);
      3'd4:    return 32'(b);
      default: return w;
    endcase
  endfunction

  // Transaction-level model: outstanding load record plus expected output registers.
  logic        m_wait = 1'b0;
  logic [4:0]  m_paddr = '0;
  logic [2:0]  m_ptype = '0;
  int unsigned m_poff = 0;
  logic        m_wena = 1'b0;
  logic [4:0]  m_waddr = '0;
  logic [31:0] m_wdata = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wait  <= 1'b0;
      m_wena  <= 1'b0;
      m_waddr <= '0;
      m_wdata <= '0;
    end else begin
      m_wena <= 1'b0;
      if (!m_wait) begin
        if (in_valid && !flush && in_rd_wena && in_rd_waddr != 5'd0) begin
          if (in_rd_sel == 2'd0 && !dmem_rvalid) begin
            m_wait  <= 1'b1;
            m_paddr <= in_rd_waddr;
            m_ptype <= in_ld_type;
            m_poff  <= int'(in_byte_off);
          end else begin
            m_wena  <= 1'b1;
            m_waddr <= in_rd_waddr;
            if (in_rd_sel == 2'd0) m_wdata <= model_load(dmem_rdata, in_ld_type, int'(in_byte_off));
            else if (in_rd_sel == 2'd2) m_wdata <= in_link_addr;
            else m_wdata <= in_alu_result;
          end
        end
      end else if (flush) begin
        m_wait <= 1'b0;
      end else if (dmem_rvalid) begin
        m_wait  <= 1'b0;
        m_wena  <= 1'b1;
        m_waddr <= m_paddr;
        m_wdata <= model_load(dmem_rdata, m_ptype, m_poff);
      end
    end
  end

  logic [4:0]  log_addr[$];
  logic [31:0] log_data[$];

  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc wena", 64'(out_rd_wena), 64'(m_wena));
      check("cyc waddr", 64'(out_rd_waddr), 64'(m_waddr));
      check("cyc wdata", 64'(out_rd_wdata), 64'(m_wdata));
      check("cyc in_ready", 64'(in_ready), 64'(!m_wait));
      check("cyc busy", 64'(out_busy), 64'(m_wait));
      if (out_rd_wena) begin
        log_addr.push_back(out_rd_waddr);
        log_data.push_back(out_rd_wdata);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid    = 1'b0;
    flush       = 1'b0;
    dmem_rvalid = 1'b0;
  endtask

  task automatic issue(input logic [1:0] sel, input logic [4:0] waddr, input logic wena,
                       input logic [2:0] ld, input logic [1:0] off, input logic [31:0] alu,
                       input logic [31:0] link, input logic rv, input logic [31:0] rd);
    in_valid      = 1'b1;
    in_rd_sel     = sel;
    in_rd_waddr   = waddr;
    in_rd_wena    = wena;
    in_ld_type    = ld;
    in_byte_off   = off;
    in_alu_result = alu;
    in_link_addr  = link;
    dmem_rvalid   = rv;
    dmem_rdata    = rd;
    flush         = 1'b0;
    tick();
  endtask

  task automatic expect_write(input string name, input logic [4:0] a, input logic [31:0] d);
    if (log_addr.size() == 0) begin
      check({name, " present"}, 64'd0, 64'd1);
    end else begin
      check({name, " addr"}, 64'(log_addr.pop_front()), 64'(a));
      check({name, " data"}, 64'(log_data.pop_front()), 64'(d));
    end
  endtask

  task automatic expect_no_write(input string name);
    check({name, " extra writes"}, 64'(log_addr.size()), 64'd0);
    log_addr.delete();
    log_data.delete();
  endtask

  localparam logic [31:0] LdWord = 32'h80F1_7F82;

  initial begin
    // Reset with random inputs.
    for (int i = 0; i < 4; i++) begin
      in_valid      = 1'($urandom);
      in_rd_wena    = 1'($urandom);
      in_rd_waddr   = 5'($urandom);
      in_rd_sel     = 2'($urandom);
      in_alu_result = $urandom;
      dmem_rvalid   = 1'($urandom);
      dmem_rdata    = $urandom;
      tick();
      check("rst wena", 64'(out_rd_wena), 64'd0);
      check("rst waddr", 64'(out_rd_waddr), 64'd0);
      check("rst wdata", 64'(out_rd_wdata), 64'd0);
      check("rst in_ready", 64'(in_ready), 64'd1);
      check("rst busy", 64'(out_busy), 64'd0);
    end
    idle();
    rst_n = 1'b1;
    issue(2'd3, 5'd1, 1'b1, 3'd0, 2'd0, 32'hA5A5_0001, 32'h0, 1'b0, 32'h0);
    idle();
    expect_write("first alu", 5'd1, 32'hA5A5_0001);

    // ALU, link, and zero-address bubble back to back.
    issue(2'd1, 5'd3, 1'b1, 3'd0, 2'd0, 32'h1234_5678, 32'h0, 1'b0, 32'h0);
    issue(2'd2, 5'd31, 1'b1, 3'd0, 2'd0, 32'h0, 32'h0040_0008, 1'b0, 32'h0);
    issue(2'd1, 5'd0, 1'b1, 3'd0, 2'd0, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'h0);
    idle();
    tick();
    expect_write("b2b alu", 5'd3, 32'h1234_5678);
    expect_write("b2b link", 5'd31, 32'h0040_0008);
    expect_no_write("b2b zero addr");

    // Load with wena=0 is a bubble and must not wait.
    issue(2'd0, 5'd4, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    idle();
    check("bubble load busy", 64'(out_busy), 64'd0);
    expect_no_write("bubble load");

    // Sub-word loads with same-cycle data.
    issue(2'd0, 5'd6, 1'b1, 3'd3, 2'd0, 32'h0, 32'h0, 1'b1, LdWord);
    expect_write("LB off0", 5'd6, 32'hFFFF_FF82);
    issue(2'd0, 5'd6, 1'b1, 3'd4, 2'd0, 32'h0, 32'h0, 1'b1, LdWord);
    expect_write("LBU off0", 5'd6, 32'h0000_0082);
    issue(2'd0, 5'd6, 1'b1, 3'd3, 2'd1, 32'h0, 32'h0, 1'b1, LdWord);
    expect_write("LB off1", 5'd6, 32'h0000_007F);
    issue(2'd0, 5'd6, 1'b1, 3'd1, 2'd2, 32'h0, 32'h0, 1'b1, LdWord);
    expect_write("LH off2", 5'd6, 32'hFFFF_80F1);
    issue(2'd0, 5'd6, 1'b1, 3'd2, 2'd3, 32'h0, 32'h0, 1'b1, LdWord);
    expect_write("LHU off3", 5'd6, 32'h0000_80F1);
    issue(2'd0, 5'd6, 1'b1, 3'd0, 2'd3, 32'h0, 32'h0, 1'b1, LdWord);
    expect_write("LW", 5'd6, 32'h80F1_7F82);
    issue(2'd0, 5'd6, 1'b1, 3'd7, 2'd1, 32'h0, 32'h0, 1'b1, LdWord);
    expect_write("ld type 7 as LW", 5'd6, 32'h80F1_7F82);
    idle();

    // Delayed LW with a younger ALU instruction held on the input.
    issue(2'd0, 5'd5, 1'b1, 3'd0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    in_rd_sel     = 2'd1;
    in_rd_waddr   = 5'd7;
    in_alu_result = 32'h0000_0077;
    for (int i = 0; i < 3; i++) begin
      check("wait busy", 64'(out_busy), 64'd1);
      check("wait in_ready", 64'(in_ready), 64'd0);
      check("wait no write", 64'(out_rd_wena), 64'd0);
      if (i == 2) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hDEAD_BEEF;
      end
      tick();
    end
    dmem_rvalid = 1'b0;
    check("delayed ready back", 64'(in_ready), 64'd1);
    expect_write("delayed LW", 5'd5, 32'hDEAD_BEEF);
    expect_no_write("held instr not early");
    tick();
    idle();
    expect_write("held alu after load", 5'd7, 32'h0000_0077);
    tick();
    expect_no_write("held alu once");

    // Flush beats a simultaneous response; a stray response is ignored.
    issue(2'd0, 5'd9, 1'b1, 3'd0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    idle();
    check("flush pre busy", 64'(out_busy), 64'd1);
    flush       = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hCAFE_0001;
    tick();
    idle();
    check("flush idle", 64'(in_ready), 64'd1);
    dmem_rvalid = 1'b1;
    tick();
    idle();
    tick();
    expect_no_write("flush and stray");

    // Accept blocked by flush in IDLE.
    issue(2'd1, 5'd12, 1'b1, 3'd0, 2'd0, 32'h0BAD_0BAD, 32'h0, 1'b0, 32'h0);
    flush = 1'b1;
    in_rd_waddr = 5'd13;
    tick();
    idle();
    tick();
    expect_write("pre-flush alu", 5'd12, 32'h0BAD_0BAD);
    expect_no_write("flushed accept");

    // Reset in the middle of a wait.
    issue(2'd0, 5'd10, 1'b1, 3'd0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    idle();
    check("midrst pre busy", 64'(out_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst busy", 64'(out_busy), 64'd0);
    check("midrst in_ready", 64'(in_ready), 64'd1);
    check("midrst wena", 64'(out_rd_wena), 64'd0);
    check("midrst wdata", 64'(out_rd_wdata), 64'd0);
    tick();
    rst_n = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1111_2222;
    tick();
    idle();
    tick();
    expect_no_write("after midrst");
    check("after midrst waddr", 64'(out_rd_waddr), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_wb_stage.md
# pipe_wb_stage

Registered, parametrised write-back stage for the five-stage pipeline, replacing the purely combinational write-back mux. It accepts MEM-stage results through a valid/ready handshake and selects among ALU result, load data and link address. It aligns and sign/zero-extends sub-word loads. It waits in a state machine for variable-latency data-memory responses, stalling upstream while it waits. It drives a one-cycle register-file write pulse whose outputs also serve as the WB forwarding source.

## Interface
- DATA_W, 32: datapath width; multiple of 8, ≥32.
- ADDR_W, 5: register-file address width.
- ZERO_SUPPRESS, 1: when 1, writes to address 0 are dropped.
- OFF_W (derived, not overridable): clog2(DATA_W/8).

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  MEM stage presents an instruction.
- in_ready  out  1  stage can accept; high iff state is IDLE.
- in_rd_waddr  in  ADDR_W  destination register.
- in_rd_wena  in  1  instruction writes a register.
- in_rd_sel  in  2  source: 0 dmem, 1 ALU, 2 link, 3 ALU.
- in_ld_type  in  3  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, other = LW.
- in_byte_off  in  OFF_W  low address bits of the load.
- in_alu_result  in  DATA_W  ALU result.
- in_link_addr  in  DATA_W  return address for link instructions.
- flush  in  1  squash the instruction being accepted or awaited.
- dmem_rvalid  in  1  load data valid this cycle.
- dmem_rdata  in  DATA_W  load data (full aligned word).
- out_rd_waddr  out  ADDR_W  register-file write address.
- out_rd_wena  out  1  register-file write strobe, one cycle per write.
- out_rd_wdata  out  DATA_W  register-file write data.
- out_busy  out  1  high in WAIT_MEM.

## Operation
- **Accept:** an instruction is accepted when in_valid && in_ready && !flush. If in_valid && flush are high together in IDLE, nothing is accepted and no write occurs.
- **Effective write enable:** in_rd_wena && !(ZERO_SUPPRESS && in_rd_waddr==0). An accepted instruction with effective enable 0 is a bubble: no write and no wait, even when in_rd_sel=0.
- **Data selection:**
  - in_rd_sel=1 or 3 selects in_alu_result.
  - in_rd_sel=2 selects in_link_addr.
  - in_rd_sel=0 selects the aligned load data.
- **Load alignment:**
  - LB/LBU: byte at bit offset 8*in_byte_off.
  - LH/LHU: halfword at offset 8*{in_byte_off[OFF_W-1:1],1'b0}; in_byte_off[0] is ignored.
  - LW: the full DATA_W value; the offset is ignored.
  - LB and LH sign-extend to DATA_W; LBU and LHU zero-extend.
- **State machine:**
  - IDLE → WAIT_MEM when a load with effective enable is accepted and dmem_rvalid=0 in that cycle. The stage latches waddr, ld_type and byte_off.
  - A load accepted with dmem_rvalid=1 in the same cycle completes directly from IDLE.
  - WAIT_MEM → IDLE when dmem_rvalid=1. The write uses dmem_rdata from that cycle.
  - WAIT_MEM → IDLE when flush=1, with no write. Flush has priority over a simultaneous dmem_rvalid.
  - Any dmem_rvalid seen in IDLE without a same-cycle accepted load is ignored, including a late response after a flush.
- **Outputs:**
  - out_rd_wena is registered and high for exactly one cycle per completed write.
  - out_rd_waddr and out_rd_wdata are registered and hold their last written values when out_rd_wena=0.
- **Reset:** asynchronous assertion, at any point including mid-WAIT_MEM, forces:
  - state IDLE;
  - out_rd_wena=0, out_rd_waddr=0, out_rd_wdata=0, out_busy=0;
  - in_ready=1;
  - no pending write survives.

## Timing
- Non-load or same-cycle-data load accepted at edge t: write visible (out_rd_wena=1) for cycle t..t+1. Latency is 1 cycle.
- Back-to-back non-loads: throughput is 1 per cycle, with in_ready held high.
- Load with data arriving at edge t+k (k≥1): in_ready=0 and out_busy=1 from t to t+k. The write is visible after t+k. in_ready returns to 1 after t+k, so the next instruction is accepted at t+k+1 at the earliest.
- in_ready and out_busy are decoded directly from the state register. They have no combinational path from in_valid, flush or dmem_rvalid.
- The cycle after reset release accepts normally.

## Test plan
- **Reset:** hold rst_n=0 with random inputs → outputs are 0, in_ready=1, no write. Release → the first ALU instruction writes normally.
- **ALU and link back-to-back:**
  - Cycle 0: sel=1, waddr=3, alu=0x1234_5678.
  - Cycle 1: sel=2, waddr=31, link=0x0040_0008.
  - Cycle 2: waddr=0, wena=1.
  - Required: writes (3,0x12345678) then (31,0x00400008); the waddr=0 instruction produces no write.
- **Sub-word loads, same-cycle data, dmem_rdata=0x80F1_7F82:**
  - LB off 0 → 0xFFFF_FF82; LBU off 0 → 0x0000_0082.
  - LB off 1 → 0x0000_007F.
  - LH off 2 → 0xFFFF_80F1; LHU off 3 → 0x0000_80F1.
  - LW → 0x80F1_7F82.
- **Delayed load:** accept LW waddr=5 with dmem_rvalid=0; assert dmem_rvalid 3 cycles later with rdata=0xDEAD_BEEF. Required:
  - in_ready=0 and out_busy=1 for 3 cycles;
  - a single write (5,0xDEADBEEF);
  - an in_valid held throughout is accepted only after the write.
- **Flush during wait:** load pending, then flush and dmem_rvalid asserted in the same cycle → no write, IDLE next cycle. A later stray dmem_rvalid produces no write.
- **Reset mid-wait:** pull rst_n low in WAIT_MEM → out_busy falls immediately. After release, dmem_rvalid=1 with no load accepted → no write.
